// File: rtl/x87_pkg.sv
// Shared x87 sequencer definitions: decoder/exec command codes, FSM state codes,
// memstore size codes and the command classification helpers.
package x87_pkg;

  localparam logic [4:0] CMD_NOP      = 5'd0;
  localparam logic [4:0] CMD_FADD_STI = 5'd1;
  localparam logic [4:0] CMD_FMUL_STI = 5'd2;
  localparam logic [4:0] CMD_FLDCW    = 5'd3;
  localparam logic [4:0] CMD_FNSTCW   = 5'd4;
  localparam logic [4:0] CMD_FXCH     = 5'd5;
  localparam logic [4:0] CMD_FLD_M32  = 5'd6;
  localparam logic [4:0] CMD_FLD_M64  = 5'd7;
  localparam logic [4:0] CMD_FSTP_M32 = 5'd8;
  localparam logic [4:0] CMD_FSTP_M64 = 5'd9;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD0   = 3'd1;
  localparam logic [2:0] ST_RD1   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_WAITD = 3'd4;
  localparam logic [2:0] ST_WR0   = 3'd5;
  localparam logic [2:0] ST_WR1   = 3'd6;
  localparam logic [2:0] ST_CMPL  = 3'd7;

  localparam logic [1:0] MS_SIZE_16 = 2'd0;
  localparam logic [1:0] MS_SIZE_32 = 2'd1;
  localparam logic [1:0] MS_SIZE_64 = 2'd2;

  function automatic logic is_load(input logic [4:0] cmd);
    logic r;
    case (cmd)
      CMD_FLDCW, CMD_FLD_M32, CMD_FLD_M64: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_two_beat_load(input logic [4:0] cmd);
    return (cmd == CMD_FLD_M64);
  endfunction

  // Control-word stores only touch the low halfword.
  function automatic logic [3:0] store_be(input logic [4:0] cmd);
    logic [3:0] be;
    case (cmd)
      CMD_FNSTCW: be = 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/x87_seq_if.sv
// Bus bundle between the x87 sequencer, the decoder, memory and the execution unit.
// master = sequencer side, slave = environment side.
interface x87_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_cmd;
  logic [2:0]  req_idx;
  logic [31:0] req_addr;

  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ack;

  logic        ex_start;
  logic [4:0]  ex_cmd;
  logic [2:0]  ex_idx;
  logic [31:0] ex_rdata32;
  logic [63:0] ex_rdata64;
  logic        ex_done;
  logic        ex_ms_valid;
  logic [1:0]  ex_ms_size;
  logic [63:0] ex_ms_data;

  logic        cmpl_valid;
  logic        cmpl_err;
  logic        busy;

  modport master (
    input  req_valid, req_cmd, req_idx, req_addr,
    output req_ready,
    output rd_req, rd_addr,
    input  rd_ack, rd_data,
    output wr_req, wr_addr, wr_data, wr_be,
    input  wr_ack,
    output ex_start, ex_cmd, ex_idx, ex_rdata32, ex_rdata64,
    input  ex_done, ex_ms_valid, ex_ms_size, ex_ms_data,
    output cmpl_valid, cmpl_err, busy
  );

  modport slave (
    output req_valid, req_cmd, req_idx, req_addr,
    input  req_ready,
    input  rd_req, rd_addr,
    output rd_ack, rd_data,
    input  wr_req, wr_addr, wr_data, wr_be,
    output wr_ack,
    input  ex_start, ex_cmd, ex_idx, ex_rdata32, ex_rdata64,
    output ex_done, ex_ms_valid, ex_ms_size, ex_ms_data,
    input  cmpl_valid, cmpl_err, busy
  );
endinterface

// File: rtl/x87_seq.sv
// x87 command sequencer: fetches memory operands, launches the execution unit,
// writes back memory stores and retires each command with an optional watchdog abort.
module x87_seq
  import x87_pkg::*;
#(
  parameter int unsigned WDOG_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  x87_seq_if.master  bus
);

  localparam logic [3:0] WDOG_LAST = 4'(WDOG_MAX - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [4:0]  cmd_r;
  logic [2:0]  idx_r;
  logic [31:0] addr_r;
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic [63:0] st_data_r;
  logic [1:0]  st_size_r;
  logic [3:0]  wdog_r;
  logic        err_r;
  logic        wdog_exp_s;

  assign wdog_exp_s = (wdog_r == WDOG_LAST);

  // Next-state decode; acks and ex_done only matter in their owning states.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) state_s = is_load(bus.req_cmd) ? ST_RD0 : ST_EXEC;
        else               state_s = ST_IDLE;
      end
      ST_RD0: begin
        if (bus.rd_ack) state_s = is_two_beat_load(cmd_r) ? ST_RD1 : ST_EXEC;
        else            state_s = ST_RD0;
      end
      ST_RD1: begin
        if (bus.rd_ack) state_s = ST_EXEC;
        else            state_s = ST_RD1;
      end
      ST_EXEC: state_s = ST_WAITD;
      ST_WAITD: begin
        if (bus.ex_done)     state_s = bus.ex_ms_valid ? ST_WR0 : ST_CMPL;
        else if (wdog_exp_s) state_s = ST_CMPL;
        else                 state_s = ST_WAITD;
      end
      ST_WR0: begin
        if (bus.wr_ack) state_s = (st_size_r == MS_SIZE_64) ? ST_WR1 : ST_CMPL;
        else            state_s = ST_WR0;
      end
      ST_WR1: begin
        if (bus.wr_ack) state_s = ST_CMPL;
        else            state_s = ST_WR1;
      end
      ST_CMPL: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, command latch, operand/store buffers and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cmd_r     <= 5'd0;
      idx_r     <= 3'd0;
      addr_r    <= 32'd0;
      lo_r      <= 32'd0;
      hi_r      <= 32'd0;
      st_data_r <= 64'd0;
      st_size_r <= 2'd0;
      wdog_r    <= 4'd0;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cmd_r     <= bus.req_cmd;
            idx_r     <= bus.req_idx;
            addr_r    <= bus.req_addr;
            lo_r      <= 32'd0;
            hi_r      <= 32'd0;
            st_data_r <= 64'd0;
            st_size_r <= 2'd0;
            wdog_r    <= 4'd0;
            err_r     <= 1'b0;
          end
        end
        ST_RD0: begin
          if (bus.rd_ack) lo_r <= bus.rd_data;
        end
        ST_RD1: begin
          if (bus.rd_ack) hi_r <= bus.rd_data;
        end
        ST_EXEC: wdog_r <= 4'd0;
        ST_WAITD: begin
          if (bus.ex_done) begin
            if (bus.ex_ms_valid) begin
              st_data_r <= bus.ex_ms_data;
              st_size_r <= bus.ex_ms_size;
            end
          end else if (wdog_exp_s) begin
            err_r <= 1'b1;
          end else begin
            wdog_r <= wdog_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // req_ready is gated by rst_n so it drops the instant reset asserts.
  assign bus.req_ready  = rst_n & (state_r == ST_IDLE);
  assign bus.busy       = (state_r != ST_IDLE);

  assign bus.rd_req     = (state_r == ST_RD0) | (state_r == ST_RD1);
  assign bus.rd_addr    = (state_r == ST_RD1) ? (addr_r + 32'd4) : addr_r;

  assign bus.wr_req     = (state_r == ST_WR0) | (state_r == ST_WR1);
  assign bus.wr_addr    = (state_r == ST_WR1) ? (addr_r + 32'd4) : addr_r;
  assign bus.wr_data    = (state_r == ST_WR1)      ? st_data_r[63:32] :
                          (cmd_r == CMD_FNSTCW)    ? {16'h0000, st_data_r[15:0]} :
                                                     st_data_r[31:0];
  assign bus.wr_be      = store_be(cmd_r);

  assign bus.ex_start   = (state_r == ST_EXEC);
  assign bus.ex_cmd     = cmd_r;
  assign bus.ex_idx     = idx_r;
  assign bus.ex_rdata32 = lo_r;
  assign bus.ex_rdata64 = {hi_r, lo_r};

  assign bus.cmpl_valid = (state_r == ST_CMPL);
  assign bus.cmpl_err   = (state_r == ST_CMPL) & err_r;

endmodule
